// File: rtl/gba_pkg.sv
// GBA EEPROM arbiter shared types, address lengths and beat counts.
// Owner/tracker state enums plus command sizing helpers.
package gba_pkg;

  typedef enum logic {
    PASS = 1'b0,
    HOST = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    G_IDLE = 2'd0,
    G_CMD  = 2'd1,
    G_RD   = 2'd2
  } gstate_e;

  localparam int ADDR_S    = 6;
  localparam int ADDR_L    = 14;
  localparam int RD_BEATS  = 68;
  localparam int DATA_BITS = 64;
  localparam int CMD_BITS  = 3;

  // widest outgoing host stream: 2 cmd + 14 addr + 64 data + stop
  localparam int SR_W = 2 + ADDR_L + DATA_BITS + 1;

  function automatic logic [6:0] addr_len(input logic model);
    return model ? 7'(ADDR_L) : 7'(ADDR_S);
  endfunction

  // write beats in a command: 3+n for read, 67+n for write
  function automatic logic [6:0] cmd_beats(
    input logic model,
    input logic rd
  );
    return (rd ? 7'(CMD_BITS) : 7'(CMD_BITS + DATA_BITS))
         + addr_len(model);
  endfunction

endpackage

// File: rtl/gba_eeprom_seq.sv
// Host beat generator: serialises a read/write command, one beat per
// 1+BEAT_GAP cycles, and shifts read bits into rdata MSB-first.
module gba_eeprom_seq
  import gba_pkg::*;
#(
  parameter int BEAT_GAP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        we,
  input  logic        model,
  input  logic [13:0] addr,
  input  logic [63:0] wdata,
  input  logic        ee_dout,
  output logic        ee_valid,
  output logic        ee_write,
  output logic        ee_din,
  output logic        done,
  output logic        ack,
  output logic [63:0] rdata
);

  logic            run;
  logic [SR_W-1:0] sr;
  logic [SR_W-1:0] sr_init;
  logic [64:0]     payload;
  logic [6:0]      bidx;
  logic [6:0]      hdr;
  logic [6:0]      last;
  logic [1:0]      gcnt;
  logic            gap_end;
  logic            wr_beat;

  // stream is left-aligned so sr[MSB] is always the next bit
  always_comb begin
    payload = we ? {wdata, 1'b0} : '0;
    if (model) sr_init = {1'b1, ~we, addr, payload};
    else       sr_init = {1'b1, ~we, addr[5:0], payload, 8'b0};
  end

  assign gap_end  = run && (gcnt == 2'(BEAT_GAP));
  assign wr_beat  = bidx < hdr;
  assign done     = gap_end && (bidx == last);
  assign ee_valid = run && (gcnt == 2'd0);
  assign ee_write = wr_beat;
  assign ee_din   = sr[SR_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run   <= 1'b0;
      sr    <= '0;
      bidx  <= '0;
      hdr   <= '0;
      last  <= '0;
      gcnt  <= '0;
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= done;
      if (start) begin
        run  <= 1'b1;
        sr   <= sr_init;
        bidx <= '0;
        gcnt <= '0;
        hdr  <= cmd_beats(model, ~we);
        last <= we ? cmd_beats(model, 1'b0) - 7'd1
                   : cmd_beats(model, 1'b1)
                     + 7'(RD_BEATS - 1);
      end else if (run) begin
        gcnt <= gap_end ? 2'd0 : gcnt + 2'd1;
        if (gap_end) begin
          if (bidx == last) begin
            run <= 1'b0;
          end else begin
            bidx <= bidx + 7'd1;
            sr   <= {sr[SR_W-2:0], 1'b0};
          end
        end
        // 68 samples pass through; the 4 leading junk bits fall off
        if (gcnt == 2'd1 && !wr_beat)
          rdata <= {rdata[62:0], ee_dout};
      end
    end
  end

endmodule

// File: rtl/gba_eeprom_arb.sv
// GBA save EEPROM port arbiter: game (bus_*) passthrough vs host block
// sequences (host_*), game framing tracker and dirty flag; ee_* to chip.
module gba_eeprom_arb
  import gba_pkg::*;
#(
  parameter int BEAT_GAP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        model,
  input  logic        bus_valid,
  input  logic        bus_write,
  input  logic        bus_din,
  output logic        bus_ready,
  output logic        bus_dout,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [13:0] host_addr,
  input  logic [63:0] host_wdata,
  output logic        host_ack,
  output logic [63:0] host_rdata,
  output logic        host_busy,
  output logic        ee_cs,
  output logic        ee_valid,
  output logic        ee_write,
  output logic        ee_din,
  input  logic        ee_ready,
  input  logic        ee_dout,
  output logic        dirty,
  input  logic        dirty_clr
);

  owner_e     owner;
  gstate_e    gst;
  logic [6:0] gcnt;
  logic [6:0] cnt_nx;
  logic       g_long;
  logic       g_rd;
  logic       acc;
  logic       start;
  logic       is_rd;
  logic       g_cmd_rd;
  logic       g_cmd_wr;
  logic       g_rd_end;
  logic       seq_valid;
  logic       seq_write;
  logic       seq_din;
  logic       seq_done;

  assign acc   = (owner == PASS) && bus_valid && ee_ready;
  // a pending game beat always beats the host to the port
  assign start = host_req && (owner == PASS)
              && (gst == G_IDLE) && !bus_valid;
  assign host_busy = (owner == HOST) || start;

  assign cnt_nx = gcnt + 7'd1;
  // second command bit decides read vs write
  assign is_rd  = (gcnt == 7'd1) ? bus_din : g_rd;

  assign g_cmd_rd = (gst == G_CMD) && acc && bus_write && is_rd
                 && (cnt_nx == cmd_beats(g_long, 1'b1));
  assign g_cmd_wr = (gst == G_CMD) && acc && bus_write && !is_rd
                 && (cnt_nx == cmd_beats(g_long, 1'b0));
  assign g_rd_end = (gst == G_RD) && acc && !bus_write
                 && (cnt_nx == 7'(RD_BEATS));

  gba_eeprom_seq #(
    .BEAT_GAP (BEAT_GAP)
  ) u_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .we       (host_we),
    .model    (model),
    .addr     (host_addr),
    .wdata    (host_wdata),
    .ee_dout  (ee_dout),
    .ee_valid (seq_valid),
    .ee_write (seq_write),
    .ee_din   (seq_din),
    .done     (seq_done),
    .ack      (host_ack),
    .rdata    (host_rdata)
  );

  always_comb begin
    ee_cs = 1'b1;
    if (owner == HOST) begin
      ee_valid  = seq_valid;
      ee_write  = seq_write;
      ee_din    = seq_din;
      bus_ready = 1'b0;
      bus_dout  = 1'b1;
    end else begin
      ee_valid  = bus_valid;
      ee_write  = bus_write;
      ee_din    = bus_din;
      bus_ready = ee_ready;
      bus_dout  = ee_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= PASS;
    end else if (start) begin
      owner <= HOST;
    end else if (seq_done) begin
      owner <= PASS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gst    <= G_IDLE;
      gcnt   <= '0;
      g_long <= 1'b0;
      g_rd   <= 1'b0;
    end else begin
      unique case (gst)
        G_IDLE: begin
          if (acc && bus_write && bus_din) begin
            gst    <= G_CMD;
            gcnt   <= 7'd1;
            g_long <= model;
          end
        end
        G_CMD: begin
          if (acc && bus_write) begin
            if (gcnt == 7'd1) g_rd <= bus_din;
            if (g_cmd_rd) begin
              gst  <= G_RD;
              gcnt <= '0;
            end else if (g_cmd_wr) begin
              gst  <= G_IDLE;
              gcnt <= '0;
            end else begin
              gcnt <= cnt_nx;
            end
          end
        end
        G_RD: begin
          if (acc && !bus_write) begin
            if (g_rd_end) begin
              gst  <= G_IDLE;
              gcnt <= '0;
            end else begin
              gcnt <= cnt_nx;
            end
          end
        end
        default: begin
          gst  <= G_IDLE;
          gcnt <= '0;
        end
      endcase
    end
  end

  // a set wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dirty <= 1'b0;
    else        dirty <= (dirty & ~dirty_clr) | g_cmd_wr;
  end

endmodule

// File: tb/tb_gba_eeprom_arb.sv
// Directed bench for gba_eeprom_arb with a behavioural serial EEPROM.
// Game beats, host sequences, arbitration, dirty and reset abort.
module tb_gba_eeprom_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        model = 1'b0;
  logic        bus_valid = 1'b0;
  logic        bus_write = 1'b0;
  logic        bus_din = 1'b0;
  logic        bus_ready;
  logic        bus_dout;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [13:0] host_addr = '0;
  logic [63:0] host_wdata = '0;
  logic        host_ack;
  logic [63:0] host_rdata;
  logic        host_busy;
  logic        ee_cs;
  logic        ee_valid;
  logic        ee_write;
  logic        ee_din;
  logic        ee_ready = 1'b1;
  logic        ee_dout = 1'b1;
  logic        dirty;
  logic        dirty_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int st_cyc, ack_cyc, done_cyc, acc_cyc;
  int g_stall, busy_viol, g_rbeats, ack_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (host_ack) ack_cnt++;

  gba_eeprom_arb #(.BEAT_GAP(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .model      (model),
    .bus_valid  (bus_valid),
    .bus_write  (bus_write),
    .bus_din    (bus_din),
    .bus_ready  (bus_ready),
    .bus_dout   (bus_dout),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .host_busy  (host_busy),
    .ee_cs      (ee_cs),
    .ee_valid   (ee_valid),
    .ee_write   (ee_write),
    .ee_din     (ee_din),
    .ee_ready   (ee_ready),
    .ee_dout    (ee_dout),
    .dirty      (dirty),
    .dirty_clr  (dirty_clr)
  );

  // behavioural EEPROM; ee_model is the chip size, fixed per test
  logic         ee_model = 1'b0;
  logic [63:0]  mem [int];
  int           m_st = 0, m_cnt = 0, m_n = 6, m_rc = 0, m_addr = 0;
  logic         m_rd = 1'b0;
  logic [127:0] m_sr = '0;
  logic [63:0]  m_data = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_st = 0;
      ee_dout <= 1'b1;
    end else if (ee_valid && ee_ready) begin
      case (m_st)
        0: if (ee_write && ee_din) begin
          m_st = 1;
          m_cnt = 1;
          m_sr = 128'd1;
          m_n = ee_model ? 14 : 6;
        end
        1: if (ee_write) begin
          m_sr = {m_sr[126:0], ee_din};
          m_cnt++;
          if (m_cnt == 2) m_rd = ee_din;
          if (m_rd && m_cnt == 3 + m_n) begin
            m_addr = int'(m_sr[14:1]) & ((1 << m_n) - 1);
            m_data = mem.exists(m_addr) ? mem[m_addr] : '1;
            m_st = 2;
            m_rc = 0;
          end else if (!m_rd && m_cnt == 67 + m_n) begin
            m_addr = int'(m_sr[78:65]) & ((1 << m_n) - 1);
            mem[m_addr] = m_sr[64:1];
            m_st = 0;
          end
        end
        2: if (!ee_write) begin
          ee_dout <= (m_rc < 4) ? 1'b0 : m_data[67 - m_rc];
          m_rc++;
          if (m_rc == 68) m_st = 0;
        end
        default: m_st = 0;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic gbeat(input logic w, input logic d, output logic r);
    int st;
    st = 0;
    @(negedge clk);
    bus_valid = 1'b1;
    bus_write = w;
    bus_din = d;
    #1;
    while (!bus_ready && st < 400) begin
      @(negedge clk);
      #1;
      st++;
    end
    if (st >= 400) chk("gbeat_timeout", 64'(st), 64'd0);
    g_stall += st;
    acc_cyc = cyc;
    @(negedge clk);
    bus_valid = 1'b0;
    r = bus_dout;
    #1;
  endtask

  task automatic game_write(input logic [13:0] a, input logic [63:0] d);
    logic r;
    gbeat(1'b1, 1'b1, r);
    gbeat(1'b1, 1'b0, r);
    for (int i = 13; i >= 0; i--) gbeat(1'b1, a[i], r);
    for (int i = 63; i >= 0; i--) gbeat(1'b1, d[i], r);
    chk("g_dirty_pre", 64'(dirty), 64'd0);
    gbeat(1'b1, 1'b0, r);
    chk("g_dirty_set", 64'(dirty), 64'd1);
  endtask

  task automatic game_read(input logic [13:0] a, output logic [63:0] d);
    logic r;
    g_rbeats = 0;
    d = '0;
    gbeat(1'b1, 1'b1, r);
    gbeat(1'b1, 1'b1, r);
    for (int i = 13; i >= 0; i--) gbeat(1'b1, a[i], r);
    gbeat(1'b1, 1'b0, r);
    for (int i = 1; i <= 68; i++) begin
      gbeat(1'b0, 1'b0, r);
      d = {d[62:0], r};
      g_rbeats = i;
      if (i < 68 && host_busy) busy_viol++;
    end
    done_cyc = cyc;
  endtask

  task automatic host_op(input logic we, input logic [13:0] a,
                         input logic [63:0] wd, output logic [63:0] rd);
    int k;
    rd = '0;
    @(negedge clk);
    host_req = 1'b1;
    host_we = we;
    host_addr = a;
    host_wdata = wd;
    #1;
    k = 0;
    while (!host_busy && k < 1000) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (k >= 1000) begin
      chk("h_start_timeout", 64'(k), 64'd0);
      host_req = 1'b0;
      return;
    end
    st_cyc = cyc;
    @(negedge clk);
    host_req = 1'b0;
    host_we = ~we;
    host_addr = ~a;
    host_wdata = ~wd;
    model = ~model;
    #1;
    k = 0;
    while (!host_ack && k < 1000) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (k >= 1000) chk("h_ack_timeout", 64'(k), 64'd0);
    ack_cyc = cyc;
    rd = host_rdata;
    @(negedge clk);
    #1;
    chk("h_ack_pulse", 64'(host_ack), 64'd0);
    model = ~model;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd, gd;
    logic        r;
    int          a0;
    mem[5] = 64'h0123456789ABCDEF;

    // reset state, passthrough while held
    bus_valid = 1'b1;
    #12;
    chk("rst_ee_valid_hi", 64'(ee_valid), 64'd1);
    chk("rst_busy", 64'(host_busy), 64'd0);
    chk("rst_ack", 64'(host_ack), 64'd0);
    chk("rst_rdata", host_rdata, 64'd0);
    chk("rst_dirty", 64'(dirty), 64'd0);
    chk("rst_cs", 64'(ee_cs), 64'd1);
    bus_valid = 1'b0;
    #1;
    chk("rst_ee_valid_lo", 64'(ee_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // host read, 6-bit model
    ee_model = 1'b0;
    model = 1'b0;
    host_op(1'b0, 14'h0005, 64'd0, rd);
    chk("h_rd6_lat", 64'(ack_cyc - st_cyc), 64'd155);
    chk("h_rd6_data", rd, 64'h0123456789ABCDEF);

    // host write then read back, 14-bit model
    ee_model = 1'b1;
    model = 1'b1;
    host_op(1'b1, 14'h1ABC, 64'hDEADBEEFCAFEF00D, rd);
    chk("h_wr14_lat", 64'(ack_cyc - st_cyc), 64'd163);
    chk("h_wr14_hold", rd, 64'h0123456789ABCDEF);
    chk("h_wr14_dirty", 64'(dirty), 64'd0);
    host_op(1'b0, 14'h1ABC, 64'd0, rd);
    chk("h_rd14_lat", 64'(ack_cyc - st_cyc), 64'd171);
    chk("h_rd14_data", rd, 64'hDEADBEEFCAFEF00D);
    chk("h_rd14_dirty", 64'(dirty), 64'd0);

    // game write + read through the bus
    g_stall = 0;
    game_write(14'h0123, 64'h1122334455667788);
    game_read(14'h0123, gd);
    chk("g_rt_data", gd, 64'h1122334455667788);
    chk("g_rt_dirty", 64'(dirty), 64'd1);
    chk("g_rt_stall", 64'(g_stall), 64'd0);
    @(negedge clk);
    dirty_clr = 1'b1;
    @(negedge clk);
    dirty_clr = 1'b0;
    #1;
    chk("g_dirty_clr", 64'(dirty), 64'd0);

    // clear held across a dirty set: set wins that cycle
    dirty_clr = 1'b1;
    game_write(14'h0124, 64'h55AA00FF33CC0F0F);
    @(negedge clk);
    #1;
    chk("g_dirty_clr2", 64'(dirty), 64'd0);
    dirty_clr = 1'b0;

    // host request mid game read
    g_stall = 0;
    busy_viol = 0;
    fork
      game_read(14'h0124, gd);
      begin
        int k;
        k = 0;
        while (g_rbeats < 30 && k < 2000) begin
          @(negedge clk);
          k++;
        end
        host_op(1'b0, 14'h1ABC, 64'd0, rd);
      end
    join
    chk("m_game_data", gd, 64'h55AA00FF33CC0F0F);
    chk("m_busy_viol", 64'(busy_viol), 64'd0);
    chk("m_stall", 64'(g_stall), 64'd0);
    chk("m_start_cyc", 64'(st_cyc), 64'(done_cyc));
    chk("m_lat", 64'(ack_cyc - st_cyc), 64'd171);
    chk("m_host_data", rd, 64'hDEADBEEFCAFEF00D);

    // same-cycle collision, then a game beat during HOST
    g_stall = 0;
    fork
      begin
        game_read(14'h0123, gd);
        @(negedge clk);
        #1;
        chk("c_bus_ready", 64'(bus_ready), 64'd0);
        chk("c_bus_dout", 64'(bus_dout), 64'd1);
        gbeat(1'b1, 1'b0, r);
      end
      host_op(1'b0, 14'h0123, 64'd0, rd);
    join
    chk("c_game_data", gd, 64'h1122334455667788);
    chk("c_start_cyc", 64'(st_cyc), 64'(done_cyc));
    chk("c_host_data", rd, 64'h1122334455667788);
    chk("c_stall_to_ack", 64'(acc_cyc), 64'(ack_cyc));

    // reset in the middle of a host write
    @(negedge clk);
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = 14'h0200;
    host_wdata = 64'hAAAA5555AAAA5555;
    #1;
    chk("r_start", 64'(host_busy), 64'd1);
    @(negedge clk);
    host_req = 1'b0;
    repeat (80) @(negedge clk);
    #1;
    chk("r_pre_busy", 64'(host_busy), 64'd1);
    a0 = ack_cnt;
    bus_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("r_ee_valid", 64'(ee_valid), 64'd1);
    chk("r_bus_ready", 64'(bus_ready), 64'd1);
    chk("r_busy", 64'(host_busy), 64'd0);
    chk("r_rdata", host_rdata, 64'd0);
    chk("r_dirty", 64'(dirty), 64'd0);
    bus_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("r_no_ack", 64'(ack_cnt - a0), 64'd0);
    host_op(1'b0, 14'h0124, 64'd0, rd);
    chk("r_after_lat", 64'(ack_cyc - st_cyc), 64'd171);
    chk("r_after_data", rd, 64'h55AA00FF33CC0F0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
